// File: rtl/dma2ip_rx_pkg.sv
// Shared stream definitions for the DMA<->IP bridge: default widths, beat struct
// and the tkeep legality rule used by both receive and transmit checkers.
package dma2ip_rx_pkg;

   localparam int DEF_DATA_W = 128;
   localparam int DEF_KEEP_W = DEF_DATA_W / 8;
   localparam int KEEP_MAX   = 64;

   typedef struct packed {
      logic [DEF_DATA_W-1:0] data;
      logic [DEF_KEEP_W-1:0] keep;
      logic                  last;
   } beat_t;

   // Legal keep: non-zero, contiguous from bit 0, and full width unless it is the last beat.
   function automatic logic keep_is_valid(input logic [KEEP_MAX-1:0] keep,
                                          input logic                last,
                                          input int unsigned         kw);
      logic [KEEP_MAX-1:0] all_ones;
      all_ones = (kw >= KEEP_MAX) ? '1 : ((KEEP_MAX'(1) << kw) - KEEP_MAX'(1));
      return (keep != '0) &&
             ((keep & (keep + KEEP_MAX'(1))) == '0) &&
             (last || (keep == all_ones));
   endfunction

endpackage

// File: rtl/dma2ip_rx_fifo.sv
// First-word-fall-through stream buffer with registered ready and wrap-bit pointers.
// Head entry is presented combinationally; outputs read as zero while empty.
module stream_fifo_fwft
   import dma2ip_rx_pkg::*;
#(
   parameter int WIDTH = 145,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   rd_valid,
   input  logic                   rd_ready,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW    = $clog2(DEPTH);
   localparam int PTR_W = AW + 1;
   localparam int LVL_W = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [LVL_W-1:0] level_r, level_nxt;
   logic             ready_r;
   logic             wr_en, rd_en;
   logic             ptr_full, ptr_empty;

   assign wr_en     = wr_valid && ready_r;
   assign rd_en     = rd_valid && rd_ready;
   assign rd_valid  = (level_r != '0);
   assign wr_ready  = ready_r;
   assign level     = level_r;
   assign rd_data   = rd_valid ? mem[rd_ptr[AW-1:0]] : '0;
   assign ptr_empty = (wr_ptr == rd_ptr);
   assign ptr_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   always_comb begin
      level_nxt = level_r;
      if (wr_en && !rd_en)
         level_nxt = level_r + LVL_W'(1);
      else if (!wr_en && rd_en)
         level_nxt = level_r - LVL_W'(1);
   end

   // Storage carries no reset; only pointers, level and ready are control state.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   // Ready is registered from the next level, so a full buffer read this cycle
   // only reopens the write side on the following cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_r <= '0;
         ready_r <= 1'b0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_en)
            rd_ptr <= rd_ptr + PTR_W'(1);
         level_r <= level_nxt;
         ready_r <= (level_nxt != LVL_W'(DEPTH));
      end
   end

   a_ptr_level_agree : assert property (@(posedge clk) disable iff (rst)
      (ptr_full == (level_r == LVL_W'(DEPTH))) && (ptr_empty == (level_r == '0)));

endmodule

// File: rtl/dma2ip_rx.sv
// Receive side of the DMA<->IP bridge: buffered AXI-Stream path to the IP plus
// packet counter and sticky tkeep protocol-error flag for debug registers.
module dma2ip_rx
   import dma2ip_rx_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int KEEP_W = DATA_W / 8,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = 32
) (
   input  logic                   s_axis_s2mm_aclk,
   input  logic                   reset,
   input  logic [DATA_W-1:0]      s_axis_s2mm_tdata,
   input  logic [KEEP_W-1:0]      s_axis_s2mm_tkeep,
   input  logic                   s_axis_s2mm_tlast,
   input  logic                   s_axis_s2mm_tvalid,
   output logic                   s_axis_s2mm_tready,
   output logic [DATA_W-1:0]      din,
   output logic [KEEP_W-1:0]      din_keep,
   output logic                   din_last,
   output logic                   din_valid,
   input  logic                   din_ready,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic [CNT_W-1:0]       pkt_count,
   output logic                   proto_err,
   input  logic                   err_clr
);

   localparam int BEAT_W = DATA_W + KEEP_W + 1;

   logic [BEAT_W-1:0] wr_beat, rd_beat;
   logic              beat_acc, pkt_done, keep_bad;

   assign wr_beat = {s_axis_s2mm_tdata, s_axis_s2mm_tkeep, s_axis_s2mm_tlast};
   assign {din, din_keep, din_last} = rd_beat;

   stream_fifo_fwft #(
      .WIDTH (BEAT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (s_axis_s2mm_aclk),
      .rst      (reset),
      .wr_data  (wr_beat),
      .wr_valid (s_axis_s2mm_tvalid),
      .wr_ready (s_axis_s2mm_tready),
      .rd_data  (rd_beat),
      .rd_valid (din_valid),
      .rd_ready (din_ready),
      .level    (fifo_level)
   );

   assign beat_acc = s_axis_s2mm_tvalid && s_axis_s2mm_tready;
   assign pkt_done = din_valid && din_ready && din_last;
   assign keep_bad = !keep_is_valid(KEEP_MAX'(s_axis_s2mm_tkeep), s_axis_s2mm_tlast, KEEP_W);

   // A bad beat in the same cycle as err_clr keeps the flag set.
   always_ff @(posedge s_axis_s2mm_aclk or posedge reset) begin
      if (reset) begin
         pkt_count <= '0;
         proto_err <= 1'b0;
      end else begin
         if (pkt_done)
            pkt_count <= pkt_count + CNT_W'(1);
         if (beat_acc && keep_bad)
            proto_err <= 1'b1;
         else if (err_clr)
            proto_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dma2ip_rx.sv
// Bench for dma2ip_rx: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations and a throttled random run.
module tb_dma2ip_rx;
   import dma2ip_rx_pkg::*;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [127:0] tdata = '0;
   logic [15:0]  tkeep = '0;
   logic         tlast = 1'b0;
   logic         tvalid = 1'b0;
   logic         tready;
   logic [127:0] din;
   logic [15:0]  din_keep;
   logic         din_last;
   logic         din_valid;
   logic         din_ready = 1'b0;
   logic [4:0]   fifo_level;
   logic [31:0]  pkt_count;
   logic         proto_err;
   logic         err_clr = 1'b0;

   int errors = 0;
   int checks = 0;

   beat_t mq[$];
   beat_t tx_q[$];
   int    m_cnt   = 0;
   bit    m_err   = 0;
   bit    m_armed = 0;

   always #5 clk = ~clk;

   dma2ip_rx dut (
      .s_axis_s2mm_aclk   (clk),
      .reset              (reset),
      .s_axis_s2mm_tdata  (tdata),
      .s_axis_s2mm_tkeep  (tkeep),
      .s_axis_s2mm_tlast  (tlast),
      .s_axis_s2mm_tvalid (tvalid),
      .s_axis_s2mm_tready (tready),
      .din                (din),
      .din_keep           (din_keep),
      .din_last           (din_last),
      .din_valid          (din_valid),
      .din_ready          (din_ready),
      .fifo_level         (fifo_level),
      .pkt_count          (pkt_count),
      .proto_err          (proto_err),
      .err_clr            (err_clr)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit keep_ok(input logic [15:0] k, input logic l);
      bit pow = 0;
      for (int i = 1; i <= 16; i++)
         if (k == 16'((32'd1 << i) - 32'd1)) pow = 1;
      return pow && (l || k == 16'hFFFF);
   endfunction

   // Reference model: a queue of held beats, updated once per clock from the stream rules.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mq.delete();
         m_cnt   = 0;
         m_err   = 0;
         m_armed = 0;
      end else begin
         bit acc, rd;
         acc = tvalid && m_armed && (mq.size() < 16);
         rd  = (mq.size() != 0) && din_ready;
         if (rd) begin
            if (mq[0].last) m_cnt++;
            void'(mq.pop_front());
         end
         if (acc) mq.push_back('{data: tdata, keep: tkeep, last: tlast});
         if (acc && !keep_ok(tkeep, tlast)) m_err = 1;
         else if (err_clr) m_err = 0;
         m_armed = 1;
      end
   end

   always @(negedge clk) begin
      beat_t h;
      h = (mq.size() != 0) ? mq[0] : '0;
      chk("tready", 128'(tready), 128'(m_armed && mq.size() != 16));
      chk("din_valid", 128'(din_valid), 128'(mq.size() != 0));
      chk("din", din, h.data);
      chk("din_keep", 128'(din_keep), 128'(h.keep));
      chk("din_last", 128'(din_last), 128'(h.last));
      chk("fifo_level", 128'(fifo_level), 128'(mq.size()));
      chk("pkt_count", 128'(pkt_count), 128'(32'(m_cnt)));
      chk("proto_err", 128'(proto_err), 128'(m_err));
   end

   task automatic cycle(output logic acc);
      @(negedge clk);
      acc = tvalid && tready;
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [127:0] d, input logic [15:0] k, input logic l);
      tdata = d; tkeep = k; tlast = l; tvalid = 1'b1;
   endtask

   task automatic send_q(input int pv, input int pr);
      logic acc;
      int   stall = 0;
      while (tx_q.size() != 0) begin
         tdata     = tx_q[0].data;
         tkeep     = tx_q[0].keep;
         tlast     = tx_q[0].last;
         tvalid    = ($urandom_range(99) < pv);
         din_ready = ($urandom_range(99) < pr);
         cycle(acc);
         if (acc) begin
            void'(tx_q.pop_front());
            stall = 0;
         end else begin
            stall++;
            if (stall > 500) begin
               chk("send_timeout", 128'(stall), 128'(0));
               tx_q.delete();
            end
         end
      end
      tvalid = 1'b0;
   endtask

   task automatic drain();
      logic acc;
      int   n = 0;
      tvalid = 1'b0;
      din_ready = 1'b1;
      while (mq.size() != 0 && n < 400) begin
         cycle(acc);
         n++;
      end
      chk("drain_done", 128'(mq.size()), 128'(0));
      cycle(acc);
   endtask

   initial begin
      logic acc;
      int   n_acc, idx, plen;
      beat_t fill[17];

      // Reset state and first-edge ready
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tready", 128'(tready), 128'(0));
      chk("rst_valid", 128'(din_valid), 128'(0));
      chk("rst_level", 128'(fifo_level), 128'(0));
      reset = 1'b0;
      #1;
      chk("rel_tready_low", 128'(tready), 128'(0));
      cycle(acc);
      chk("rel_tready_high", 128'(tready), 128'(1));

      // 4-beat packet, 1-cycle latency
      din_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         put({4{32'hA0A0_0000 + 32'(i)}}, (i == 3) ? 16'h00FF : 16'hFFFF, i == 3);
         cycle(acc);
         chk("pkt1_acc", 128'(acc), 128'(1));
         if (i == 0) begin
            chk("lat_valid", 128'(din_valid), 128'(1));
            chk("lat_data", din, {4{32'hA0A0_0000}});
         end
      end
      drain();
      chk("pkt1_count", 128'(pkt_count), 128'(1));
      chk("pkt1_err", 128'(proto_err), 128'(0));

      // Fill with IP stalled
      for (int i = 0; i < 17; i++)
         fill[i] = '{data: {4{32'hB000_0000 + 32'(i)}},
                     keep: (i == 16) ? 16'h00FF : 16'hFFFF, last: (i >= 15)};
      din_ready = 1'b0;
      n_acc = 0;
      idx = 0;
      for (int c = 0; c < 24; c++) begin
         put(fill[idx].data, fill[idx].keep, fill[idx].last);
         cycle(acc);
         if (acc) begin
            n_acc++;
            idx++;
         end
      end
      chk("fill_count", 128'(n_acc), 128'(16));
      chk("fill_level", 128'(fifo_level), 128'(16));
      chk("fill_tready", 128'(tready), 128'(0));

      // Full with simultaneous read: no bypass write
      din_ready = 1'b1;
      cycle(acc);
      chk("full_rd_nowrite", 128'(acc), 128'(0));
      chk("full_rd_level", 128'(fifo_level), 128'(15));
      chk("full_rd_tready", 128'(tready), 128'(1));
      din_ready = 1'b0;
      cycle(acc);
      chk("refill_write", 128'(acc), 128'(1));
      chk("refill_level", 128'(fifo_level), 128'(16));
      drain();
      chk("fill_pkts", 128'(pkt_count), 128'(3));

      // Protocol error set / clear / set-wins
      din_ready = 1'b1;
      put({4{32'hC0DE_0001}}, 16'h0F0F, 1'b1);
      cycle(acc);
      tvalid = 1'b0;
      chk("err_set", 128'(proto_err), 128'(1));
      chk("err_fwd_keep", 128'(din_keep), 128'(16'h0F0F));
      err_clr = 1'b1;
      cycle(acc);
      err_clr = 1'b0;
      chk("err_clr", 128'(proto_err), 128'(0));
      err_clr = 1'b1;
      put({4{32'hC0DE_0002}}, 16'h0000, 1'b1);
      cycle(acc);
      tvalid = 1'b0;
      err_clr = 1'b0;
      chk("err_set_wins", 128'(proto_err), 128'(1));
      err_clr = 1'b1;
      cycle(acc);
      err_clr = 1'b0;
      drain();
      chk("err_pkts", 128'(pkt_count), 128'(5));

      // Reset with 5 buffered and a packet half delivered
      din_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 40 && idx < 8; c++) begin
         put({4{32'hD000_0000 + 32'(idx)}}, 16'hFFFF, idx == 7);
         cycle(acc);
         if (acc) idx++;
      end
      tvalid = 1'b0;
      din_ready = 1'b1;
      repeat (3) cycle(acc);
      din_ready = 1'b0;
      cycle(acc);
      chk("pre_rst_level", 128'(fifo_level), 128'(5));
      #1 reset = 1'b1;
      #1;
      chk("mid_rst_valid", 128'(din_valid), 128'(0));
      chk("mid_rst_level", 128'(fifo_level), 128'(0));
      chk("mid_rst_count", 128'(pkt_count), 128'(0));
      chk("mid_rst_din", din, 128'(0));
      @(posedge clk);
      #1 reset = 1'b0;
      cycle(acc);
      for (int i = 0; i < 3; i++)
         tx_q.push_back('{data: {4{32'hE000_0000 + 32'(i)}}, keep: (i == 2) ? 16'h0007 : 16'hFFFF, last: i == 2});
      send_q(100, 100);
      drain();
      chk("post_rst_pkts", 128'(pkt_count), 128'(1));

      // Throttled random traffic
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      for (int p = 0; p < 1000; p++) begin
         plen = $urandom_range(40, 1);
         for (int b = 0; b < plen; b++)
            tx_q.push_back('{data: {$urandom, $urandom, $urandom, $urandom},
                             keep: (b == plen - 1) ? 16'((32'd1 << $urandom_range(16, 1)) - 32'd1) : 16'hFFFF,
                             last: (b == plen - 1)});
         send_q(80, 70);
      end
      drain();
      chk("rand_pkts", 128'(pkt_count), 128'(1000));
      chk("rand_err", 128'(proto_err), 128'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
